// File: rtl/seq_accum_alu.sv
// seq_accum_alu: 2W-bit accumulator ALU with one-cycle ADD/SUB/LOAD/PRESET/RESET
// and W-cycle iterative MUL (shift-add) and DIV/MOD (restoring division).
// The accumulator output only changes when a result is written or on reset.
module seq_accum_alu #(
  parameter int W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VALID,
  output logic             READY,
  input  logic [3:0]       OP,
  input  logic [W-1:0]     IN,
  output logic [2*W-1:0]   OUT,
  output logic [1:0]       ERR,
  output logic             DONE
);

  localparam int CNT_W = $clog2(W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       opa_q, opa_d;      // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [W-1:0]       opb_q, opb_d;      // divisor
  logic [2*W-1:0]     mcand_q, mcand_d;  // multiplicand, shifted left each iteration
  logic [2*W-1:0]     prod_q, prod_d;    // partial product
  logic [W-1:0]       rem_q, rem_d;      // partial remainder
  logic               mod_q, mod_d;      // 1: return remainder, 0: return quotient
  logic [2*W-1:0]     out_q, out_d;
  logic [1:0]         err_q, err_d;
  logic               done_q, done_d;

  logic               accept_s;
  logic [W-1:0]       a_s;
  logic [W:0]         sum_s;
  logic [2*W-1:0]     diff_s;
  logic               borrow_s;
  logic [2*W-1:0]     prod_step_s;
  logic [W:0]         rem_sh_s;
  logic [W:0]         trial_s;
  logic               ge_s;
  logic [W-1:0]       rem_step_s;
  logic [W-1:0]       quo_step_s;
  logic               last_s;

  assign accept_s    = VALID && (state_q == ST_IDLE);
  assign a_s         = out_q[W-1:0];
  assign sum_s       = {1'b0, a_s} + {1'b0, IN};
  assign diff_s      = {{W{1'b0}}, a_s} - {{W{1'b0}}, IN};
  assign borrow_s    = (IN > a_s);
  // One shift-add step: the current multiplier bit is opa_q[0].
  assign prod_step_s = opa_q[0] ? (prod_q + mcand_q) : prod_q;
  // One restoring-division step: bring down the next dividend bit, try to subtract.
  assign rem_sh_s    = {rem_q, opa_q[W-1]};
  assign trial_s     = rem_sh_s - {1'b0, opb_q};
  assign ge_s        = ~trial_s[W];
  assign rem_step_s  = ge_s ? trial_s[W-1:0] : rem_sh_s[W-1:0];
  assign quo_step_s  = {opa_q[W-2:0], ge_s};
  assign last_s      = (cnt_q == CNT_W'(W - 1));

  // Next-state, datapath and result selection for all states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    mod_d   = mod_q;
    out_d   = out_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          done_d = 1'b1;
          case (OP)
            4'b0000: err_d = 2'b00;
            4'b0001: begin
              out_d = {{W{1'b0}}, IN};
              err_d = 2'b00;
            end
            4'b0010: begin
              out_d = {{(W-1){1'b0}}, sum_s};
              err_d = {1'b0, sum_s[W]};
            end
            4'b0011: begin
              out_d = diff_s;
              err_d = {1'b0, borrow_s};
            end
            4'b0100: begin
              done_d  = 1'b0;
              state_d = ST_MUL;
              cnt_d   = {CNT_W{1'b0}};
              prod_d  = {(2*W){1'b0}};
              mcand_d = {{W{1'b0}}, IN};
              opa_d   = a_s;
            end
            4'b0101, 4'b0110: begin
              if (IN == {W{1'b0}}) begin
                // Divide by zero is resolved immediately without iterating.
                out_d = {(2*W){1'b0}};
                err_d = 2'b10;
              end else begin
                done_d  = 1'b0;
                state_d = ST_DIV;
                cnt_d   = {CNT_W{1'b0}};
                opa_d   = a_s;
                opb_d   = IN;
                rem_d   = {W{1'b0}};
                mod_d   = (OP == 4'b0110);
              end
            end
            4'b1110: begin
              out_d = {(2*W){1'b1}};
              err_d = 2'b00;
            end
            4'b1111: begin
              out_d = {(2*W){1'b0}};
              err_d = 2'b00;
            end
            default: err_d = 2'b11;
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      ST_MUL: begin
        prod_d  = prod_step_s;
        mcand_d = {mcand_q[2*W-2:0], 1'b0};
        opa_d   = {1'b0, opa_q[W-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_s) begin
          out_d   = prod_step_s;
          err_d   = 2'b00;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        rem_d = rem_step_s;
        opa_d = quo_step_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_s) begin
          if (mod_q) begin
            out_d = {{W{1'b0}}, rem_step_s};
          end else begin
            out_d = {{W{1'b0}}, quo_step_s};
          end
          err_d   = 2'b00;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      opa_q   <= {W{1'b0}};
      opb_q   <= {W{1'b0}};
      mcand_q <= {(2*W){1'b0}};
      prod_q  <= {(2*W){1'b0}};
      rem_q   <= {W{1'b0}};
      mod_q   <= 1'b0;
      out_q   <= {(2*W){1'b0}};
      err_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      mod_q   <= mod_d;
      out_q   <= out_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign READY = (state_q == ST_IDLE);
  assign OUT   = out_q;
  assign ERR   = err_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_seq_accum_alu.sv
// Directed testbench for seq_accum_alu (W=16) with hand-computed expectations.
module tb_seq_accum_alu;

  localparam int W = 16;

  logic            CLK;
  logic            RST_N;
  logic            VALID;
  logic            READY;
  logic [3:0]      OP;
  logic [W-1:0]    IN;
  logic [2*W-1:0]  OUT;
  logic [1:0]      ERR;
  logic            DONE;

  int n_cmp;
  int n_bad;
  int busy;

  seq_accum_alu #(.W(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .VALID (VALID),
    .READY (READY),
    .OP    (OP),
    .IN    (IN),
    .OUT   (OUT),
    .ERR   (ERR),
    .DONE  (DONE)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present one request for exactly one rising edge; returns 1 ns after that edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] val);
    @(negedge CLK);
    VALID = 1'b1;
    OP    = op;
    IN    = val;
    @(posedge CLK);
    #1;
    VALID = 1'b0;
  endtask

  // Count busy cycles until READY returns; optionally drive an ADD request meanwhile.
  task automatic wait_ready(input logic junk);
    busy = 0;
    if (junk) begin
      VALID = 1'b1;
      OP    = 4'b0010;
      IN    = 16'h0001;
    end
    while (!READY && busy < 100) begin
      busy++;
      @(posedge CLK);
      #1;
    end
    VALID = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST_N = 1'b0;
    VALID = 1'b0;
    OP    = 4'b0000;
    IN    = 16'h0000;
    #12;
    check_eq("rst_out",   OUT,   64'h0);
    check_eq("rst_err",   ERR,   64'h0);
    check_eq("rst_done",  DONE,  64'h0);
    check_eq("rst_ready", READY, 64'h1);
    @(negedge CLK);
    RST_N = 1'b1;

    // 1: LOAD 5 then ADD 7 back to back
    issue(4'b0001, 16'd5);
    check_eq("load5_out",  OUT,  64'h5);
    check_eq("load5_done", DONE, 64'h1);
    issue(4'b0010, 16'd7);
    check_eq("add7_out",   OUT,   64'h0000000C);
    check_eq("add7_err",   ERR,   64'h0);
    check_eq("add7_done",  DONE,  64'h1);
    check_eq("add7_ready", READY, 64'h1);
    @(posedge CLK); #1;
    check_eq("add7_done_off", DONE, 64'h0);

    // 2: ADD overflow, SUB borrow, ERR holds while idle
    issue(4'b0001, 16'hFFFF);
    issue(4'b0010, 16'h0001);
    check_eq("addov_out", OUT, 64'h00010000);
    check_eq("addov_err", ERR, 64'h1);
    issue(4'b0001, 16'd3);
    issue(4'b0011, 16'd5);
    check_eq("sub_out", OUT, 64'hFFFFFFFE);
    check_eq("sub_err", ERR, 64'h1);
    @(posedge CLK); #1;
    check_eq("err_hold",  ERR,  64'h1);
    check_eq("done_idle", DONE, 64'h0);

    // 3: MUL 0xFFFF*0xFFFF with an ignored ADD during busy
    issue(4'b0001, 16'hFFFF);
    issue(4'b0100, 16'hFFFF);
    check_eq("mul_ready_low", READY, 64'h0);
    check_eq("mul_out_hold",  OUT,   64'h0000FFFF);
    check_eq("mul_done_busy", DONE,  64'h0);
    wait_ready(1'b1);
    check_eq("mul_busy_cycles", busy, 64'd16);
    check_eq("mul_out",  OUT,  64'hFFFE0001);
    check_eq("mul_err",  ERR,  64'h0);
    check_eq("mul_done", DONE, 64'h1);
    @(posedge CLK); #1;
    check_eq("mul_after_out",  OUT,  64'hFFFE0001);
    check_eq("mul_after_done", DONE, 64'h0);

    // 4: DIV, MOD, divide by zero, NOP clears ERR
    issue(4'b0001, 16'd100);
    issue(4'b0101, 16'd7);
    wait_ready(1'b0);
    check_eq("div_cycles", busy, 64'd16);
    check_eq("div_out",  OUT,  64'd14);
    check_eq("div_done", DONE, 64'h1);
    issue(4'b0001, 16'd100);
    issue(4'b0110, 16'd7);
    wait_ready(1'b0);
    check_eq("mod_cycles", busy, 64'd16);
    check_eq("mod_out", OUT, 64'd2);
    check_eq("mod_err", ERR, 64'h0);
    issue(4'b0101, 16'd0);
    check_eq("div0_out",   OUT,   64'h0);
    check_eq("div0_err",   ERR,   64'h2);
    check_eq("div0_done",  DONE,  64'h1);
    check_eq("div0_ready", READY, 64'h1);
    issue(4'b0000, 16'd9);
    check_eq("nop_out", OUT, 64'h0);
    check_eq("nop_err", ERR, 64'h0);

    // 5: async reset in the middle of a MUL
    issue(4'b0001, 16'd3);
    issue(4'b0100, 16'd5);
    repeat (8) @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check_eq("arst_ready", READY, 64'h1);
    check_eq("arst_out",   OUT,   64'h0);
    check_eq("arst_err",   ERR,   64'h0);
    check_eq("arst_done",  DONE,  64'h0);
    repeat (2) @(posedge CLK);
    #1;
    check_eq("arst_no_done", DONE, 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check_eq("arst_no_late_done", DONE, 64'h0);
    check_eq("arst_out_stay",     OUT,  64'h0);
    issue(4'b0001, 16'd9);
    check_eq("post_load_out",  OUT,  64'd9);
    check_eq("post_load_done", DONE, 64'h1);

    // 6: illegal opcode, PRESET, RESET, MUL uses only low half
    issue(4'b1010, 16'd1);
    check_eq("ill_out",  OUT,  64'd9);
    check_eq("ill_err",  ERR,  64'h3);
    check_eq("ill_done", DONE, 64'h1);
    issue(4'b1110, 16'd0);
    check_eq("preset_out", OUT, 64'hFFFFFFFF);
    check_eq("preset_err", ERR, 64'h0);
    issue(4'b0100, 16'd2);
    wait_ready(1'b0);
    check_eq("mul2_out", OUT, 64'h0001FFFE);
    issue(4'b1111, 16'd0);
    check_eq("reset_op_out", OUT, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
